// File: rtl/prbs_checker.sv
// prbs_checker: receive-side PRBS checker for the Galois LFSR pattern generator.
// Self-synchronises from the received bitstream, reports lock, pulses on every
// mismatched bit while locked and keeps a saturating error count.
// Optional feature macro: PRBS_CHECKER_BITCNT_EN adds a 32-bit count of bits
// sampled while locked (bit_cnt) so BER = err_cnt / bit_cnt.
//
// Handshake: d_in is consumed on a rising clk edge only when enable is high;
// with enable low the checker holds every piece of state and err_pulse drops.
module prbs_checker #(
    parameter int               width       = 32,
    parameter logic [width-1:0] polynomial  = 32'h00400006,
    parameter int               LOCK_COUNT  = 64,
    parameter int               UNLOCK_ERRS = 8,
    parameter int               CNT_W       = 16
) (
    input  logic             clk,
    input  logic             res_n,
    input  logic             enable,
    input  logic             clear,
    input  logic             d_in,
    output logic             locked,
    output logic             err_pulse,
`ifdef PRBS_CHECKER_BITCNT_EN
    output logic [31:0]      bit_cnt,
`endif
    output logic [CNT_W-1:0] err_cnt
);

    localparam int                FILL_W     = $clog2(width + 1);
    localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(width);
    localparam logic [15:0]       LOCK_TGT   = 16'(LOCK_COUNT);
    localparam logic [7:0]        UNLOCK_TGT = 8'(UNLOCK_ERRS);

    typedef enum logic {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [width-1:0]   hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [15:0]        match_q, match_d;
    logic [7:0]         bad_q, bad_d;
    logic               err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
`ifdef PRBS_CHECKER_BITCNT_EN
    logic [31:0]        bit_cnt_q, bit_cnt_d;
`endif

    logic               pred;
    logic               pred_valid;
    logic               mismatch;
    logic [width-1:0]   hist_shift;

    // Predict the next bit from the history: oldest bit plus every tapped bit.
    always_comb begin
        pred = hist_q[width-1];
        for (int i = 1; i < width; i++) begin
            if (polynomial[i]) begin
                pred = pred ^ hist_q[width-1-i];
            end
        end
    end

    assign pred_valid = (fill_q == FILL_FULL);
    assign mismatch   = enable && (d_in != pred);
    assign hist_shift = {hist_q[width-2:0], d_in};

    // Next-state logic: history fill, search/lock FSM, error accounting.
    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        fill_d      = fill_q;
        match_d     = match_q;
        bad_d       = bad_q;
        err_pulse_d = 1'b0;
        err_cnt_d   = err_cnt_q;
`ifdef PRBS_CHECKER_BITCNT_EN
        bit_cnt_d   = bit_cnt_q;
`endif
        if (clear) begin
            state_d   = ST_SEARCH;
            hist_d    = '0;
            fill_d    = '0;
            match_d   = '0;
            bad_d     = '0;
            err_cnt_d = '0;
`ifdef PRBS_CHECKER_BITCNT_EN
            bit_cnt_d = '0;
`endif
        end else if (enable) begin
            hist_d = hist_shift;
            if (!pred_valid) begin
                fill_d = fill_q + FILL_W'(1);
            end
            if (state_q == ST_LOCKED) begin
`ifdef PRBS_CHECKER_BITCNT_EN
                if (bit_cnt_q != 32'hFFFF_FFFF) begin
                    bit_cnt_d = bit_cnt_q + 32'd1;
                end
`endif
                if (mismatch) begin
                    err_pulse_d = 1'b1;
                    if (err_cnt_q != {CNT_W{1'b1}}) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                    end
                    if (bad_q + 8'd1 == UNLOCK_TGT) begin
                        state_d = ST_SEARCH;
                        match_d = '0;
                        bad_d   = '0;
                    end else begin
                        bad_d = bad_q + 8'd1;
                    end
                end else begin
                    bad_d = '0;
                end
                // An all-zero history means a dead line, not a pattern: resync.
                if (hist_shift == '0) begin
                    state_d = ST_SEARCH;
                    match_d = '0;
                    bad_d   = '0;
                end
            end else if (pred_valid) begin
                if (mismatch || (hist_q == '0)) begin
                    match_d = '0;
                end else begin
                    match_d = match_q + 16'd1;
                    if (match_q + 16'd1 == LOCK_TGT) begin
                        state_d = ST_LOCKED;
                        bad_d   = '0;
                    end
                end
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q     <= ST_SEARCH;
            hist_q      <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            bad_q       <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
`ifdef PRBS_CHECKER_BITCNT_EN
            bit_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            bad_q       <= bad_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
`ifdef PRBS_CHECKER_BITCNT_EN
            bit_cnt_q   <= bit_cnt_d;
`endif
        end
    end

    assign locked    = (state_q == ST_LOCKED);
    assign err_pulse = err_pulse_q;
    assign err_cnt   = err_cnt_q;
`ifdef PRBS_CHECKER_BITCNT_EN
    assign bit_cnt   = bit_cnt_q;
`endif

endmodule
